sram_cfg_loader: RTL and testbench
==================================

# sram_cfg_loader

Serial configuration loader for the fabric's LUT/config SRAMs. Accepts a bit-serial configuration stream over a valid/ready handshake, packs it into DATA_WIDTH-bit words and sequentially writes every SRAM address from 0 to 2**ADDR_WIDTH-1 through the SRAM's write port. It sits between the chip-level bitstream shifter and one `sram` instance and reports completion. Optionally, it reads the SRAM back and checks it.

## Interface
- ADDR_WIDTH, 4, SRAM address width; the SRAM depth is N = 2**ADDR_WIDTH.
- DATA_WIDTH, 1, SRAM word width; this is the number of stream bits per word.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a load. Sampled in IDLE and DONE only.
- cfg_valid  in  1  stream bit valid.
- cfg_data  in  1  stream bit.
- cfg_ready  out  1  loader can accept a bit.
- sram_we  out  1  SRAM write enable.
- sram_waddr  out  ADDR_WIDTH  SRAM write address.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_raddr  out  ADDR_WIDTH  SRAM read address (readback).
- sram_rdata  in  DATA_WIDTH  SRAM read data. Combinational from sram_raddr.
- busy  out  1  a load or readback is in progress.
- done  out  1  load complete. Level signal, held until the next start or rst.
- error  out  1  readback mismatch. Valid while done=1.

## Operation
- States:
  - IDLE
  - SHIFT
  - WRITE
  - VERIFY (only when CFG_READBACK_EN is defined)
  - DONE
- Reset values:
  - State is IDLE; word address, bit counter, shift register and parity accumulators are all 0.
  - All outputs are 0.
- IDLE/DONE:
  - cfg_ready=0.
  - If start=1: go to SHIFT; clear done, error, address, bit counter and accumulators.
- SHIFT:
  - cfg_ready=1 and busy=1.
  - A bit is accepted when cfg_valid && cfg_ready. Bits arrive LSB first into word bit[bitcnt].
  - When the DATA_WIDTH-th bit is accepted: go to WRITE and reset bitcnt to 0.
  - If cfg_valid=0, hold state with no timeout.
- WRITE (exactly one cycle):
  - sram_we=1, sram_waddr=addr, sram_wdata=the assembled word; cfg_ready=0.
  - The word is XOR-folded into the write-parity accumulator.
  - If addr==N-1: go to VERIFY, or to DONE when the macro is absent. Otherwise increment addr and return to SHIFT.
- The address counter never wraps within a load. Each load writes exactly N words, once each, in ascending order.
- start while busy is ignored. Stream bits offered outside SHIFT are not accepted.
- rst mid-load aborts to IDLE. Words already written stay in the SRAM; the remaining addresses keep their old contents.
- All outputs are driven from registers or state decode only, with no combinational path from inputs.

## Timing
- Each word costs DATA_WIDTH SHIFT cycles plus 1 WRITE cycle when cfg_valid is held high. Full load: N*(DATA_WIDTH+1) cycles from the first SHIFT cycle.
- The SRAM word is updated at the rising edge that ends the WRITE cycle. A subsequent write to that address cannot occur for at least DATA_WIDTH cycles.
- Without the macro: done=1 and busy=0 from the edge that ends the final WRITE.
- With the macro:
  - VERIFY lasts N cycles. In cycle k, sram_raddr=k and sram_rdata is XOR-folded into the read-parity accumulator.
  - At the edge ending cycle N-1: enter DONE with error = (read parity != write parity).
- start in DONE takes effect the next cycle. done drops in the same edge that enters SHIFT.

## Configuration
- CFG_READBACK_EN defined:
  - The VERIFY state exists and sram_raddr sweeps 0..N-1.
  - error reports a parity mismatch.
  - Load latency grows by N cycles.
- CFG_READBACK_EN undefined:
  - No VERIFY state and no read-parity logic.
  - sram_raddr is tied to 0 and error is tied to 0.
  - WRITE of address N-1 goes directly to DONE.

## Test plan
- Basic load (ADDR_WIDTH=2, DATA_WIDTH=4):
  - Stimulus: rst, start, then stream words 0x1, 0x2, 0x3, 0xA LSB-first with cfg_valid held high.
  - Required: SRAM holds {0x1,0x2,0x3,0xA}; sram_we pulses exactly 4 times at waddr 0,1,2,3; done rises 20 cycles after the first SHIFT cycle (24 with the macro); error=0.
- Handshake stalls:
  - Stimulus: same stream, with cfg_valid dropped for 3 cycles in the middle of word 2.
  - Required: identical SRAM contents; done is delayed by exactly 3 cycles; cfg_ready=0 in every WRITE cycle.
- Readback fault (macro on):
  - Stimulus: the bench forces sram_rdata to 0x0 while raddr=1.
  - Required: done=1 with error=1.
- Reset mid-load:
  - Stimulus: assert rst during word 3 (addr=2).
  - Required: next cycle all outputs are 0 and state is IDLE; SRAM addresses 0 and 1 hold the new data, address 2 and above hold the old data.
- Restart and ignored start:
  - Stimulus: pulse start while busy; then, after done, pulse start and load 0xF×4.
  - Required: the mid-load start has no effect; done clears on restart; the SRAM ends at all 0xF.
- Default parameters (ADDR_WIDTH=4, DATA_WIDTH=1):
  - Stimulus: stream 16 alternating bits 1,0,1,0,...
  - Required: odd addresses hold 0, even addresses hold 1; done rises 32 cycles after the first SHIFT cycle (48 with the macro).

Source files
------------

// File: rtl/sram_cfg_loader.sv
// sram_cfg_loader: serial configuration loader for one fabric config SRAM.
// Packs a bit-serial valid/ready stream (LSB first) into DATA_WIDTH-bit words
// and writes addresses 0..2**ADDR_WIDTH-1 in ascending order, once each.
// Optional readback check is enabled by defining CFG_READBACK_EN; it sweeps
// the read port after the last write and compares XOR-folded parities.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SHIFT  | accepting stream bits into the word being assembled
// WRITE  | one-cycle SRAM write of the assembled word
// VERIFY | readback sweep of every address (CFG_READBACK_EN only)
// DONE   | load finished, done held until next start or rst
module sram_cfg_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  cfg_valid,
  input  logic                  cfg_data,
  output logic                  cfg_ready,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

`ifdef CFG_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_VERIFY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;
`endif

  state_t state, state_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic [BIT_W-1:0]      bitcnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] bit_sel;
  logic                  load_start;
  logic                  bit_take;

  // a new load is only honoured from IDLE or DONE
  assign load_start = start && ((state == S_IDLE) || (state == S_DONE));
  // cfg_ready is exactly "in SHIFT", so acceptance only needs cfg_valid there
  assign bit_take   = cfg_valid && (state == S_SHIFT);
  assign bit_sel    = DATA_WIDTH'(1) << bitcnt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // next-state and state-decoded outputs
  always_comb begin
    state_d   = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    sram_we   = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_valid && (bitcnt == BIT_LAST)) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        sram_we = 1'b1;
        if (addr == ADDR_LAST) begin
`ifdef CFG_READBACK_EN
          state_d = S_VERIFY;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_SHIFT;
        end
      end
`ifdef CFG_READBACK_EN
      S_VERIFY: begin
        busy = 1'b1;
        if (sram_raddr == ADDR_LAST) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // word assembly, bit counter and write address
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else if (load_start) begin
      addr   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else if (bit_take) begin
      shreg  <= cfg_data ? (shreg | bit_sel) : (shreg & ~bit_sel);
      bitcnt <= (bitcnt == BIT_LAST) ? '0 : bitcnt + 1'b1;
    end else if ((state == S_WRITE) && (addr != ADDR_LAST)) begin
      addr <= addr + 1'b1;
    end
  end

  assign sram_waddr = addr;
  assign sram_wdata = shreg;

`ifdef CFG_READBACK_EN
  logic [DATA_WIDTH-1:0] wpar;
  logic [DATA_WIDTH-1:0] rpar;
  logic [ADDR_WIDTH-1:0] rcnt;
  logic                  err_q;

  // parity of everything written and everything read back
  always_ff @(posedge clk) begin
    if (rst) begin
      wpar  <= '0;
      rpar  <= '0;
      rcnt  <= '0;
      err_q <= 1'b0;
    end else if (load_start) begin
      wpar  <= '0;
      rpar  <= '0;
      rcnt  <= '0;
      err_q <= 1'b0;
    end else if (state == S_WRITE) begin
      wpar <= wpar ^ shreg;
    end else if (state == S_VERIFY) begin
      rpar <= rpar ^ sram_rdata;
      // the final read folds in combinationally so the verdict lands on entry to DONE
      if (rcnt == ADDR_LAST) err_q <= ((rpar ^ sram_rdata) != wpar);
      else                   rcnt  <= rcnt + 1'b1;
    end
  end

  assign sram_raddr = rcnt;
  assign error      = err_q;
`else
  logic rdata_unused;

  assign rdata_unused = ^sram_rdata;
  assign sram_raddr   = '0;
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_sram_cfg_loader.sv
// Bench for sram_cfg_loader: instance A (ADDR_WIDTH=2, DATA_WIDTH=4) runs the
// directed and randomized loads, instance B uses the default parameters.
// Written SRAM words go through a scoreboard queue popped by a write monitor.
`timescale 1ns/1ps
module tb_sram_cfg_loader;
  localparam int AW  = 2;
  localparam int DW  = 4;
  localparam int N   = 4;
  localparam int BAW = 4;
  localparam int BN  = 16;
`ifdef CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t0, b_t0;

  logic rst, start, cfg_valid, cfg_data;
  logic cfg_ready, sram_we, busy, done, error;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, rdata;
  logic [DW-1:0] mem [N];
  logic [DW-1:0] exp_mem [N];
  bit rd_force = 1'b0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  logic b_start, b_valid, b_data, b_ready, b_we, b_busy, b_done, b_error;
  logic [BAW-1:0] b_waddr, b_raddr;
  logic [0:0] b_wdata, b_rdata;
  logic [0:0] b_mem [BN];
  logic b_exp [BN];
  int b_next = 0;

  sram_cfg_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_a (
    .clk(clk), .rst(rst), .start(start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .sram_we(sram_we), .sram_waddr(waddr), .sram_wdata(wdata),
    .sram_raddr(raddr), .sram_rdata(rdata), .busy(busy), .done(done), .error(error)
  );

  sram_cfg_loader u_b (
    .clk(clk), .rst(rst), .start(b_start), .cfg_valid(b_valid), .cfg_data(b_data),
    .cfg_ready(b_ready), .sram_we(b_we), .sram_waddr(b_waddr), .sram_wdata(b_wdata),
    .sram_raddr(b_raddr), .sram_rdata(b_rdata), .busy(b_busy), .done(b_done), .error(b_error)
  );

  // SRAM models: synchronous write, combinational read, optional forced fault
  assign rdata   = (rd_force && (raddr == AW'(1))) ? '0 : mem[raddr];
  assign b_rdata = b_mem[b_raddr];
  always @(posedge clk) if (sram_we) mem[waddr] <= wdata;
  always @(posedge clk) if (b_we) b_mem[b_waddr] <= b_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // write monitor for instance A: pop the scoreboard on every write
  always @(negedge clk) begin
    if (sram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL a_write: got unexpected write addr=%0d data=%0h, expected none", waddr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (waddr !== mon_e.a || wdata !== mon_e.d) begin
          errors++;
          $display("FAIL a_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   waddr, wdata, mon_e.a, mon_e.d);
        end
      end
      chk("a_ready_in_write", cfg_ready, 0);
    end
  end

  // write monitor for instance B: ascending addresses with the expected bit
  always @(negedge clk) begin
    if (b_we) begin
      chk("b_waddr", b_waddr, b_next[BAW-1:0]);
      chk("b_wdata", b_wdata, b_exp[b_next % BN]);
      chk("b_ready_in_write", b_ready, 0);
      b_next++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_ready"}, cfg_ready, 0);
    chk({tag, "_we"}, sram_we, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    chk("a_done_clear_on_start", done, 0);
    chk("a_busy_after_start", busy, 1);
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = b;
    forever begin
      @(negedge clk);
      acc = cfg_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL a_bit_timeout: got no cfg_ready in %0d cycles, expected acceptance", n);
        break;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int stall_bit, input int stall_n,
                           input bit hold_start);
    start = hold_start;
    for (int i = 0; i < DW; i++) begin
      if (i == stall_bit && stall_n > 0) begin
        cfg_valid = 1'b0;
        repeat (stall_n) tick();
      end
      send_bit(w[i]);
    end
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat_exp, input logic err_exp);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done || n > 300) break;
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, cyc - t0, lat_exp);
    chk({tag, "_error"}, error, err_exp);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
    for (int i = 0; i < N; i++) chk({tag, "_mem"}, mem[i], exp_mem[i]);
  endtask

  // full load on A; sw/sb/sn place a mid-word stall, stw holds start during a word
  task automatic load(input string tag, input logic [DW-1:0] w [N], input int sw, input int sb,
                      input int sn, input int stw, input bit frc);
    logic [DW-1:0] par_w, par_r;
    wr_t e;
    int lat;
    par_w = '0;
    par_r = '0;
    rd_force = frc;
    do_start();
    for (int i = 0; i < N; i++) begin
      e.a = AW'(i);
      e.d = w[i];
      exp_q.push_back(e);
      exp_mem[i] = w[i];
      send_word(w[i], (i == sw) ? sb : -1, sn, (i == stw));
    end
    for (int i = 0; i < N; i++) begin
      par_w ^= w[i];
      par_r ^= (frc && i == 1) ? '0 : w[i];
    end
    lat = N * (DW + 1) + ((sw >= 0) ? sn : 0) + (RB ? N : 0);
    wait_done(tag, lat, RB ? (par_w != par_r) : 1'b0);
    rd_force = 1'b0;
  endtask

  task automatic b_load(input string tag, input logic bits [BN]);
    logic acc;
    int n;
    for (int i = 0; i < BN; i++) b_exp[i] = bits[i];
    b_next  = 0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_t0 = cyc;
    chk({tag, "_busy_after_start"}, b_busy, 1);
    chk({tag, "_done_clear"}, b_done, 0);
    b_valid = 1'b1;
    for (int i = 0; i < BN; i++) begin
      b_data = bits[i];
      n = 0;
      forever begin
        @(negedge clk);
        acc = b_ready;
        tick();
        if (acc) break;
        n++;
        if (n > 50) begin
          checks++;
          errors++;
          $display("FAIL %s_bit_timeout: got no cfg_ready in %0d cycles, expected acceptance", tag, n);
          break;
        end
      end
    end
    b_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (b_done || n > 300) break;
      n++;
    end
    chk({tag, "_done"}, b_done, 1);
    chk({tag, "_latency"}, cyc - b_t0, BN * 2 + (RB ? BN : 0));
    chk({tag, "_error"}, b_error, 0);
    chk({tag, "_writes"}, b_next, BN);
    for (int i = 0; i < BN; i++) chk({tag, "_mem"}, b_mem[i], bits[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] words [N];
    logic [DW-1:0] old [N];
    logic bits [BN];
    wr_t e;

    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
    b_start = 1'b0; b_valid = 1'b0; b_data = 1'b0;
    repeat (3) tick();
    a_outputs_zero("reset");
    chk("b_reset_busy", b_busy, 0);
    chk("b_reset_done", b_done, 0);
    chk("b_reset_ready", b_ready, 0);
    rst = 1'b0;
    tick();

    // basic load
    words = '{4'h1, 4'h2, 4'h3, 4'hA};
    load("basic", words, -1, 0, 0, -1, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk("done_held", done, 1);
    chk("busy_held_low", busy, 0);

    // three-cycle stall in the middle of word 2
    load("stall", words, 2, 2, 3, -1, 1'b0);

    // readback fault on address 1
    words = '{4'h5, DW'($urandom_range(1, 15)), 4'hC, 4'h6};
    load("rb_fault", words, -1, 0, 0, -1, 1'b1);

    // reset during word at address 2
    for (int i = 0; i < N; i++) begin
      old[i]   = exp_mem[i];
      words[i] = old[i] ^ DW'($urandom_range(1, 15));
    end
    do_start();
    for (int i = 0; i < 2; i++) begin
      e.a = AW'(i);
      e.d = words[i];
      exp_q.push_back(e);
      exp_mem[i] = words[i];
      send_word(words[i], -1, 0, 1'b0);
    end
    send_bit(words[2][0]);
    send_bit(words[2][1]);
    rst = 1'b1;
    tick();
    a_outputs_zero("midrst");
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_idle_ready", cfg_ready, 0);
    chk("midrst_sb_drained", exp_q.size(), 0);
    for (int i = 0; i < N; i++) chk("midrst_mem", mem[i], exp_mem[i]);

    // start pulsed while busy, then restart from DONE with all-ones
    for (int i = 0; i < N; i++) words[i] = DW'($urandom);
    load("ignored_start", words, -1, 0, 0, 1, 1'b0);
    words = '{4'hF, 4'hF, 4'hF, 4'hF};
    load("restart", words, -1, 0, 0, -1, 1'b0);

    // randomized loads with random mid-word stalls
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) words[i] = DW'($urandom);
      load("random", words, int'($urandom_range(0, N - 1)), int'($urandom_range(1, DW - 1)),
           int'($urandom_range(1, 4)), -1, 1'b0);
    end

    // default parameters: alternating stream, then a random one
    for (int i = 0; i < BN; i++) bits[i] = ((i % 2) == 0);
    b_load("b_alt", bits);
    for (int i = 0; i < BN; i++) bits[i] = $urandom_range(0, 1) != 0;
    b_load("b_rand", bits);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
